// File: rtl/mul_share_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mul_share_ctrl
//  Purpose  : Round-robin controller that lets two requesters share one
//             repeated-add multiplier datapath (A, B, P registers).
//  Revision : 1.0 - initial release
// ============================================================================
module mul_share_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic             eqz,
    input  logic [WIDTH-1:0] p_in,
    output logic [WIDTH-1:0] data_in,
    output logic             LdA,
    output logic             LdB,
    output logic             LdP,
    output logic             clrp,
    output logic             decB,
    output logic [WIDTH-1:0] result,
    output logic             done0,
    output logic             done1,
    output logic             busy,
    output logic             owner
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOADA = 3'd1,
        LOADB = 3'd2,
        ADD   = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_q,  last_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             grant;

    // Next-state logic: arbitration in IDLE, fixed sequence afterwards.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        // On a tie the requester that was not served last wins.
        grant    = (req0 && req1) ? ~last_q : req1;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    owner_d = grant;
                    a_d     = grant ? a1 : a0;
                    b_d     = grant ? b1 : b0;
                    state_d = LOADA;
                end
            end
            LOADA: state_d = LOADB;
            LOADB: state_d = ADD;
            ADD: begin
                if (eqz) begin
                    result_d = p_in;
                    state_d  = DONE;
                end
            end
            DONE: begin
                last_d  = owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and data registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
        end
    end

    // Moore output decode of state/owner; only eqz (datapath status) gates LdP/decB.
    always_comb begin
        data_in = '0;
        LdA     = 1'b0;
        LdB     = 1'b0;
        LdP     = 1'b0;
        clrp    = 1'b0;
        decB    = 1'b0;
        done0   = 1'b0;
        done1   = 1'b0;
        case (state_q)
            LOADA: begin
                data_in = a_q;
                LdA     = 1'b1;
            end
            LOADB: begin
                data_in = b_q;
                LdB     = 1'b1;
                clrp    = 1'b1;
            end
            ADD: begin
                LdP  = ~eqz;
                decB = ~eqz;
            end
            DONE: begin
                done0 = ~owner_q;
                done1 = owner_q;
            end
            default: ;
        endcase
    end

    assign busy   = (state_q != IDLE);
    assign owner  = owner_q;
    assign result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_share_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mul_share_ctrl
//  Purpose  : Scoreboard bench for mul_share_ctrl with a repeated-add datapath.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mul_share_ctrl;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0 = 1'b0, req1 = 1'b0;
    logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic         eqz;
    logic [W-1:0] p_in;
    logic [W-1:0] data_in, result;
    logic         LdA, LdB, LdP, clrp, decB, done0, done1, busy, owner;

    mul_share_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .eqz(eqz), .p_in(p_in), .data_in(data_in),
        .LdA(LdA), .LdB(LdB), .LdP(LdP), .clrp(clrp), .decB(decB),
        .result(result), .done0(done0), .done1(done1), .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    // Repeated-add datapath (deliberately not reset).
    logic [W-1:0] dp_a = '0, dp_b = '0, dp_p = '0;
    always @(posedge clk) begin
        if (LdA)  dp_a <= data_in;
        if (LdB)  dp_b <= data_in;
        if (decB) dp_b <= dp_b - 1'b1;
        if (clrp) dp_p <= '0;
        if (LdP)  dp_p <= dp_p + dp_a;
    end
    assign eqz  = (dp_b == '0);
    assign p_in = dp_p;

    typedef struct {
        logic         own;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        int           lat;
        int           ldp;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   n_done = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    // Monitor: follows each operation and compares against the queue head.
    initial begin
        int   cyc;
        int   ldp;
        bit   active;
        exp_t e;
        cyc = 0; ldp = 0; active = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                cyc = 0; ldp = 0; active = 0;
            end else begin
                if (active) cyc++;
                if (LdA) begin
                    active = 1; cyc = 1; ldp = 0;
                    if (exp_q.size() == 0) begin
                        bad++; total++;
                        $display("FAIL grant: unexpected grant, no operation queued");
                    end else begin
                        chk("loada_data", 32'(data_in), 32'(exp_q[0].a));
                    end
                end
                if (LdB && exp_q.size() != 0) begin
                    chk("loadb_data", 32'(data_in), 32'(exp_q[0].b));
                    chk("loadb_clrp", 32'(clrp), 32'd1);
                end
                if (LdP) ldp++;
                if (done0 || done1) begin
                    n_done++;
                    if (exp_q.size() == 0) begin
                        bad++; total++;
                        $display("FAIL done: unexpected done0=%0d done1=%0d", done0, done1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("done_owner", {30'd0, done1, done0}, e.own ? 32'd2 : 32'd1);
                        chk("result", 32'(result), 32'(e.res));
                        chk("latency", 32'(cyc), 32'(e.lat));
                        chk("ldp_count", 32'(ldp), 32'(e.ldp));
                    end
                    active = 0;
                end
            end
        end
    end

    task automatic push_exp(input logic own, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.own = own; e.a = a; e.b = b;
        e.res = W'(a * b);
        e.lat = int'(b) + 4;
        e.ldp = int'(b);
        exp_q.push_back(e);
    endtask

    // Waits (bounded) until the done counter reaches target, then returns inside DONE.
    task automatic wait_done(input int target);
        int k;
        for (k = 0; k < 2000; k++) begin
            @(negedge clk); #1;
            if (n_done >= target) break;
        end
        if (n_done < target) begin
            bad++; total++;
            $display("FAIL timeout: done count %0d expected %0d", n_done, target);
            exp_q.delete();
        end
    endtask

    task automatic do_op(input logic r, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit drop_early);
        int target;
        target = n_done + 1;
        @(negedge clk);
        if (r) begin a1 = a; b1 = b; req1 = 1'b1; end
        else   begin a0 = a; b0 = b; req0 = 1'b1; end
        push_exp(r, a, b);
        if (drop_early) begin
            @(negedge clk);
            chk("busy_after_grant", 32'(busy), 32'd1);
            req0 = 1'b0; req1 = 1'b0;
        end
        wait_done(target);
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_owner", 32'(owner), 32'(r));
    endtask

    initial begin
        int target;
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_outputs", {26'd0, LdA, LdB, LdP, clrp, decB, done0 | done1}, 32'd0);
        chk("rst_data_in", 32'(data_in), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        rst = 1'b0;

        // Simultaneous requests after reset: strict alternation starting with 0
        a0 = 16'd3; b0 = 16'd4; a1 = 16'd7; b1 = 16'd2;
        push_exp(1'b0, 16'd3, 16'd4);
        push_exp(1'b1, 16'd7, 16'd2);
        push_exp(1'b0, 16'd3, 16'd4);
        push_exp(1'b1, 16'd7, 16'd2);
        target = n_done + 4;
        req0 = 1'b1; req1 = 1'b1;
        wait_done(target);
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        chk("rr_idle_busy", 32'(busy), 32'd0);

        // Single operations
        do_op(1'b0, 16'd17, 16'd5, 1'b0);
        do_op(1'b1, 16'd9, 16'd0, 1'b0);
        do_op(1'b0, 16'd300, 16'd300, 1'b0);

        // Reset in the middle of ADD aborts without a done pulse
        @(negedge clk);
        a0 = 16'd5; b0 = 16'd10; req0 = 1'b1;
        push_exp(1'b0, 16'd5, 16'd10);
        @(negedge clk); req0 = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        target = n_done;
        #2 rst = 1'b1;
        #1;
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_ctrl", {26'd0, LdA, LdB, LdP, clrp, decB, done0 | done1}, 32'd0);
        chk("async_rst_data", 32'(data_in), 32'd0);
        exp_q.delete();
        @(negedge clk); rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("no_done_after_abort", 32'(n_done), 32'(target));
        chk("rst_result_cleared", 32'(result), 32'd0);
        do_op(1'b0, 16'd5, 16'd10, 1'b0);

        // Request dropped right after the grant still completes
        do_op(1'b1, 16'd6, 16'd3, 1'b1);

        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mul_share_ctrl.md
MUL_SHARE_CTRL -- requirements
Module: mul_share_ctrl

Interface
REQ-001 Parameter: WIDTH, 16, operand/product width in bits.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req0, req1  input  1 each  requester 0/1 operation request, level-sensitive.
REQ-005 a0, b0, a1, b1  input  WIDTH each  multiplicand/multiplier of requester 0/1.
REQ-006 eqz  input  1  from repeated-add datapath, high when its B register is 0.
REQ-007 p_in  input  WIDTH  product register value from the datapath.
REQ-008 data_in  output  WIDTH  operand bus to the datapath.
REQ-009 LdA, LdB, LdP, clrp, decB  output  1 each  datapath controls: load A, load B, P<=P+A, clear P, B<=B-1.
REQ-010 result  output  WIDTH  last completed product, registered.
REQ-011 done0, done1  output  1 each  one-cycle completion pulse to requester 0/1.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 owner  output  1  index of the requester being served; holds the last value in IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, LOADA, LOADB, ADD and DONE.
REQ-015 In IDLE, if any req is high, the FSM SHALL grant one requester, latch its a/b into internal registers, set owner, and go to LOADA; otherwise it stays in IDLE.
REQ-016 Arbitration SHALL be round-robin: a single request wins, and on a tie the requester not served last wins; last-served resets to 1, so req0 wins the first tie.
REQ-017 LOADA (1 cycle) SHALL drive data_in=latched a with LdA=1, then go to LOADB.
REQ-018 LOADB (1 cycle) SHALL drive data_in=latched b with LdB=1 and clrp=1, then go to ADD.
REQ-019 In ADD with eqz=0, the FSM SHALL assert LdP=1 and decB=1 and stay in ADD.
REQ-020 In ADD with eqz=1, the FSM SHALL assert no datapath control, capture p_in into result at the edge, and go to DONE.
REQ-021 DONE (1 cycle) SHALL assert done[owner]=1, update last-served to owner, and go to IDLE.
REQ-022 data_in SHALL be 0, and each datapath control SHALL be 0, in every state or cycle not listed above for it.
REQ-023 Latency: with multiplier b, ADD SHALL last b+1 cycles, and done SHALL be high in the (b+4)th cycle after the grant edge.
REQ-024 Issue rate: at most one operation in flight, and the next grant occurs no earlier than the edge leaving the IDLE that follows DONE.
REQ-025 req, a and b SHALL be ignored outside IDLE; dropping req mid-operation does not abort, and done still pulses.
REQ-026 A req still high in the IDLE after its DONE SHALL be treated as a new request, subject to round-robin.
REQ-027 result SHALL hold its value until the next ADD-exit capture; WIDTH overflow wraps mod 2^WIDTH with no flag.
REQ-028 b=0 SHALL give zero LdP pulses and result=0.
REQ-029 Outputs SHALL be Moore decodes of state/owner, with no combinational path from req/a/b to any output.

Reset
REQ-030 rst=1 SHALL immediately set state=IDLE, owner=0, last-served=1, result=0, and latched a/b=0, and force data_in, all datapath controls, done0, done1 and busy to 0.
REQ-031 rst asserted mid-operation SHALL abort it with no done pulse; the datapath is not reset, and the next operation's clrp re-initialises P.
REQ-032 After rst falls, the first grant SHALL occur at the first rising edge with any req high.

Verification (bench uses the team's repeated-add datapath)
REQ-033 req0, a0=17, b0=5 -> one LdA cycle with data_in=17; one LdB+clrp cycle with data_in=5; exactly 5 LdP/decB cycles; done0 in cycle 9 after the grant edge; result=85; done1 never asserted.
REQ-034 req1, a1=9, b1=0 -> zero LdP cycles; done1 in cycle 4 after the grant edge; result=0.
REQ-035 req0 and req1 rise together after reset (a0=3, b0=4, a1=7, b1=2), both held -> order 0,1,0,1 with results 12,14,12,14; no back-to-back grant to the same requester.
REQ-036 req0 with a0=300, b0=300 -> result=24464 (90000 mod 65536); 300 LdP cycles.
REQ-037 rst pulsed during the ADD of a0=5, b0=10 -> all outputs 0 asynchronously; no done0; a fresh req0 with a0=5, b0=10 -> result=50.
REQ-038 req1 dropped one cycle after the grant -> operation completes, done1 pulses, and the FSM returns to IDLE with busy=0.
